// File: rtl/rr_onehot_mux_reg_pkg.sv
// ----------------------------------------------------------------------------
// rr_onehot_mux_reg_pkg
//   Shared constants and helpers for the round-robin one-hot mux register.
//   The helpers work on the widest supported channel count (MAX_INS).
//   Narrower one-hot vectors are zero-extended by the caller, and the
//   caller truncates the result.
// ----------------------------------------------------------------------------
package rr_onehot_mux_reg_pkg;

    localparam int MAX_INS   = 16;
    localparam int MAX_IDX_W = $clog2(MAX_INS);

    // One-hot to binary index. OR-reduction form: every set bit contributes
    // its own index. A one-hot input therefore gives the exact index.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(
        input logic [MAX_INS-1:0] oh
    );
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_INS; i++) begin
            if (oh[i]) begin
                idx = idx | i[MAX_IDX_W-1:0];
            end
        end
        return idx;
    endfunction

    // Binary index to one-hot.
    function automatic logic [MAX_INS-1:0] idx_to_onehot(
        input logic [MAX_IDX_W-1:0] idx
    );
        logic [MAX_INS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_onehot_mux_reg_if.sv
// ----------------------------------------------------------------------------
// rr_onehot_mux_reg_if
//   Bundles the N producer channels and the single consumer channel of the
//   arbitrating mux register.
//
//   Handshake: a transfer happens on a channel in any cycle where both valid
//   and ready are high at the rising clock edge. A producer that raises valid
//   keeps valid and its data stable until that transfer. Ready may depend on
//   valid but never on data.
//
//   Signals:
//     in_valid [N_INS]          producer request per channel
//     in_data  [N_INS][WIDTH]   producer payload per channel
//     in_ready [N_INS]          accept per channel (one-hot or zero)
//     out_valid                 output register holds an entry
//     out_data [WIDTH]          registered payload
//     out_sel  [N_INS]          one-hot source channel of out_data
//     out_ready                 consumer accepts the output entry
//   Modports: master = producers + consumer side, slave = the mux.
// ----------------------------------------------------------------------------
interface rr_onehot_mux_reg_if #(
    parameter int WIDTH = 32,
    parameter int N_INS = 4
);
    logic [N_INS-1:0]            in_valid;
    logic [N_INS-1:0][WIDTH-1:0] in_data;
    logic [N_INS-1:0]            in_ready;
    logic                        out_valid;
    logic [WIDTH-1:0]            out_data;
    logic [N_INS-1:0]            out_sel;
    logic                        out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_onehot_mux_reg_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational one-hot arbiter.
//   RR_EN=1: the first requester scanning from ptr upward, with wrap.
//   RR_EN=0: the lowest-index requester (ptr ignored).
//
//   Ports:
//     req   [N_INS]   request vector
//     ptr   [PTR_W]   highest-priority channel in round-robin mode
//     grant [N_INS]   one-hot grant, zero when no request
// ----------------------------------------------------------------------------
module rr_arbiter
    import rr_onehot_mux_reg_pkg::*;
#(
    parameter  int N_INS = 4,
    parameter  int RR_EN = 1,
    localparam int PTR_W = $clog2(N_INS)
) (
    input  logic [N_INS-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_INS-1:0] grant
);

    logic [2*N_INS-1:0]   req2;
    logic [PTR_W-1:0]     start;
    logic [MAX_IDX_W-1:0] win;
    logic                 found;

    // The request vector is doubled so the wrap-around scan is one linear
    // pass. Positions below 'start' are masked. The first unmasked hit wins.
    // 'found' latches the first hit, so no loop exit is needed.
    always_comb begin
        req2  = {req, req};
        start = (RR_EN != 0) ? ptr : '0;
        win   = '0;
        found = 1'b0;
        for (int j = 0; j < 2 * N_INS; j++) begin
            if (!found && (j >= int'(start)) && req2[j]) begin
                found = 1'b1;
                win   = (j >= N_INS) ? MAX_IDX_W'(j - N_INS) : MAX_IDX_W'(j);
            end
        end
        grant = found ? N_INS'(idx_to_onehot(win)) : '0;
    end

endmodule

// File: rtl/rr_onehot_mux_reg.sv
// ----------------------------------------------------------------------------
// rr_onehot_mux_reg
//   Registered N-input arbitrating mux. Each cycle one valid channel is
//   granted, either round-robin or by fixed priority. Its payload is
//   captured into a single-entry output register. The register can refill
//   in the cycle it drains, which sustains one transfer per cycle.
//
//   Ports:
//     clk      clock, all state on posedge
//     rst      synchronous active-high reset
//     bus      slave side of rr_onehot_mux_reg_if (inputs + output channel)
//     dbg_ptr  current round-robin priority pointer (observation only)
// ----------------------------------------------------------------------------
module rr_onehot_mux_reg
    import rr_onehot_mux_reg_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_INS = 4,
    parameter  int RR_EN = 1,
    localparam int PTR_W = $clog2(N_INS)
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_onehot_mux_reg_if.slave   bus,
    output logic [PTR_W-1:0]     dbg_ptr
);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [N_INS-1:0]     out_sel_q,   out_sel_d;
    logic [PTR_W-1:0]     ptr_q,       ptr_d;

    logic [N_INS-1:0]     grant;
    logic [N_INS-1:0]     in_ready;
    logic                 can_load;
    logic                 xfer;
    logic [WIDTH-1:0]     sel_data;
    logic [MAX_IDX_W-1:0] gidx;

    rr_arbiter #(
        .N_INS (N_INS),
        .RR_EN (RR_EN)
    ) u_arb (
        .req   (bus.in_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // The entry leaves when the consumer takes it, so a refill in the
    // same cycle is safe.
    assign can_load = !out_valid_q || bus.out_ready;
    assign in_ready = rst ? '0 : (grant & {N_INS{can_load}});
    // in_ready is a subset of grant, and grant is a subset of in_valid.
    assign xfer     = |in_ready;
    assign gidx     = onehot_to_idx(MAX_INS'(grant));

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_INS; i++) begin
            sel_data = sel_data | (bus.in_data[i] & {WIDTH{grant[i]}});
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = grant;
            if (RR_EN != 0) begin
                ptr_d = (gidx == MAX_IDX_W'(N_INS - 1)) ? '0
                                                         : PTR_W'(gidx + 1'b1);
            end
        end else if (bus.out_ready) begin
            // Drain only. Data and sel keep their last values.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign dbg_ptr       = ptr_q;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(in_ready));

    a_sel_onehot: assert property (@(posedge clk) disable iff (rst)
        out_valid_q |-> $onehot(out_sel_q));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !bus.out_ready) |=> ($stable(out_data_q) && $stable(out_sel_q)));

endmodule

// File: tb/tb_rr_onehot_mux_reg.sv
module tb_rr_onehot_mux_reg;

    localparam int WIDTH = 32;
    localparam int N_INS = 4;

    typedef struct {
        logic             rst;
        logic [3:0]       valid;
        logic [31:0]      base;     // in_data[i] = base + i
        logic             rdy;
        logic [3:0]       exp_ir;   // in_ready before the edge
        logic             exp_ov;   // state after the edge
        logic [31:0]      exp_data;
        logic [3:0]       exp_sel;
        logic [1:0]       exp_ptr;
    } vec_t;

    localparam int NVEC = 27;

    logic       clk;
    logic       rst;
    logic [1:0] rr_ptr;
    logic [1:0] fp_ptr;

    int tests_run;
    int tests_failed;
    int ch3_grants;

    vec_t vecs[NVEC];

    rr_onehot_mux_reg_if #(.WIDTH(WIDTH), .N_INS(N_INS)) rr_bus ();
    rr_onehot_mux_reg_if #(.WIDTH(WIDTH), .N_INS(N_INS)) fp_bus ();

    rr_onehot_mux_reg #(.WIDTH(WIDTH), .N_INS(N_INS), .RR_EN(1)) dut_rr (
        .clk     (clk),
        .rst     (rst),
        .bus     (rr_bus.slave),
        .dbg_ptr (rr_ptr)
    );

    rr_onehot_mux_reg #(.WIDTH(WIDTH), .N_INS(N_INS), .RR_EN(0)) dut_fp (
        .clk     (clk),
        .rst     (rst),
        .bus     (fp_bus.slave),
        .dbg_ptr (fp_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Producer rule: a pending request keeps valid and data until taken.
    for (genvar g = 0; g < N_INS; g++) begin : g_prod
        a_rr_prod: assert property (@(posedge clk) disable iff (rst)
            (rr_bus.in_valid[g] && !rr_bus.in_ready[g]) |=>
            (rr_bus.in_valid[g] && $stable(rr_bus.in_data[g])));
        a_fp_prod: assert property (@(posedge clk) disable iff (rst)
            (fp_bus.in_valid[g] && !fp_bus.in_ready[g]) |=>
            (fp_bus.in_valid[g] && $stable(fp_bus.in_data[g])));
    end

    // ---------------- helpers ----------------
    function automatic vec_t mk(
        input logic rst_i, input logic [3:0] valid, input logic [31:0] base,
        input logic rdy, input logic [3:0] exp_ir, input logic exp_ov,
        input logic [31:0] exp_data, input logic [3:0] exp_sel,
        input logic [1:0] exp_ptr
    );
        vec_t v;
        v.rst = rst_i; v.valid = valid; v.base = base; v.rdy = rdy;
        v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_data = exp_data;
        v.exp_sel = exp_sel; v.exp_ptr = exp_ptr;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive_rr(input logic [3:0] valid, input logic [31:0] base,
                            input logic rdy);
        rr_bus.in_valid  = valid;
        rr_bus.out_ready = rdy;
        for (int i = 0; i < N_INS; i++) rr_bus.in_data[i] = base + 32'(i);
    endtask

    task automatic drive_fp(input logic [3:0] valid, input logic [31:0] base,
                            input logic rdy);
        fp_bus.in_valid  = valid;
        fp_bus.out_ready = rdy;
        for (int i = 0; i < N_INS; i++) fp_bus.in_data[i] = base + 32'(i);
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        ch3_grants   = 0;
        rst          = 1'b1;
        drive_rr(4'b0000, 32'h0, 1'b1);
        drive_fp(4'b0000, 32'h0, 1'b1);

        //             rst valid    base      rdy  exp_ir   ov    data      sel      ptr
        // reset held two cycles with every channel requesting
        vecs[0]  = mk(1, 4'b1111, 32'hA0,   1, 4'b0000, 0, 32'h0,    4'b0000, 2'd0);
        vecs[1]  = mk(1, 4'b1111, 32'hA0,   1, 4'b0000, 0, 32'h0,    4'b0000, 2'd0);
        // round-robin fairness: A0 A1 A2 A3 A0
        vecs[2]  = mk(0, 4'b1111, 32'hA0,   1, 4'b0001, 1, 32'hA0,   4'b0001, 2'd1);
        vecs[3]  = mk(0, 4'b1111, 32'hA0,   1, 4'b0010, 1, 32'hA1,   4'b0010, 2'd2);
        vecs[4]  = mk(0, 4'b1111, 32'hA0,   1, 4'b0100, 1, 32'hA2,   4'b0100, 2'd3);
        vecs[5]  = mk(0, 4'b1111, 32'hA0,   1, 4'b1000, 1, 32'hA3,   4'b1000, 2'd0);
        vecs[6]  = mk(0, 4'b1111, 32'hA0,   1, 4'b0001, 1, 32'hA0,   4'b0001, 2'd1);
        // serve remaining pending channels down to channel 3
        vecs[7]  = mk(0, 4'b1110, 32'hA0,   1, 4'b0010, 1, 32'hA1,   4'b0010, 2'd2);
        vecs[8]  = mk(0, 4'b1100, 32'hA0,   1, 4'b0100, 1, 32'hA2,   4'b0100, 2'd3);
        vecs[9]  = mk(0, 4'b1000, 32'hA0,   1, 4'b1000, 1, 32'hA3,   4'b1000, 2'd0);
        // pointer wrapped to 0: 0101 -> channel 0, then skip 1 -> channel 2
        vecs[10] = mk(0, 4'b0101, 32'hA0,   1, 4'b0001, 1, 32'hA0,   4'b0001, 2'd1);
        vecs[11] = mk(0, 4'b0101, 32'hA0,   1, 4'b0100, 1, 32'hA2,   4'b0100, 2'd3);
        vecs[12] = mk(0, 4'b0001, 32'hA0,   1, 4'b0001, 1, 32'hA0,   4'b0001, 2'd1);
        // drain, then idle with out_ready low
        vecs[13] = mk(0, 4'b0000, 32'hA0,   1, 4'b0000, 0, 32'hA0,   4'b0001, 2'd1);
        vecs[14] = mk(0, 4'b0000, 32'hA0,   0, 4'b0000, 0, 32'hA0,   4'b0001, 2'd1);
        // load 0xDEAD from channel 1 into an empty register, consumer stalled
        vecs[15] = mk(0, 4'b0010, 32'hDEAC, 0, 4'b0010, 1, 32'hDEAD, 4'b0010, 2'd2);
        // backpressure for 5 cycles
        vecs[16] = mk(0, 4'b0011, 32'hB0,   0, 4'b0000, 1, 32'hDEAD, 4'b0010, 2'd2);
        vecs[17] = mk(0, 4'b0011, 32'hB0,   0, 4'b0000, 1, 32'hDEAD, 4'b0010, 2'd2);
        vecs[18] = mk(0, 4'b0011, 32'hB0,   0, 4'b0000, 1, 32'hDEAD, 4'b0010, 2'd2);
        vecs[19] = mk(0, 4'b0011, 32'hB0,   0, 4'b0000, 1, 32'hDEAD, 4'b0010, 2'd2);
        vecs[20] = mk(0, 4'b0011, 32'hB0,   0, 4'b0000, 1, 32'hDEAD, 4'b0010, 2'd2);
        // release: refill in the draining cycle (ptr=2 wraps to channel 0)
        vecs[21] = mk(0, 4'b0011, 32'hB0,   1, 4'b0001, 1, 32'hB0,   4'b0001, 2'd1);
        vecs[22] = mk(0, 4'b0010, 32'hB0,   1, 4'b0010, 1, 32'hB1,   4'b0010, 2'd2);
        // reset mid-stream with a held entry and ptr=2
        vecs[23] = mk(1, 4'b0101, 32'hC0,   0, 4'b0000, 0, 32'h0,    4'b0000, 2'd0);
        vecs[24] = mk(0, 4'b0101, 32'hC0,   1, 4'b0001, 1, 32'hC0,   4'b0001, 2'd1);
        vecs[25] = mk(0, 4'b0100, 32'hC0,   1, 4'b0100, 1, 32'hC2,   4'b0100, 2'd3);
        vecs[26] = mk(0, 4'b0000, 32'hC0,   1, 4'b0000, 0, 32'hC2,   4'b0100, 2'd3);

        for (int k = 0; k < NVEC; k++) begin
            rst = vecs[k].rst;
            drive_rr(vecs[k].valid, vecs[k].base, vecs[k].rdy);
            #1;
            check("rr_in_ready", k, 32'(rr_bus.in_ready), 32'(vecs[k].exp_ir));
            @(posedge clk);
            #1;
            check("rr_out_valid", k, 32'(rr_bus.out_valid), 32'(vecs[k].exp_ov));
            check("rr_out_data",  k, rr_bus.out_data,       vecs[k].exp_data);
            check("rr_out_sel",   k, 32'(rr_bus.out_sel),   32'(vecs[k].exp_sel));
            check("rr_ptr",       k, 32'(rr_ptr),           32'(vecs[k].exp_ptr));
        end

        // Fixed priority: channels 1..3 held valid, channel 1 wins every cycle.
        rst = 1'b0;
        drive_rr(4'b0000, 32'h0, 1'b1);
        drive_fp(4'b1110, 32'hE0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            #1;
            check("fp_in_ready", k, 32'(fp_bus.in_ready), 32'h2);
            if (fp_bus.in_ready[3]) ch3_grants++;
            @(posedge clk);
            #1;
            check("fp_out_valid", k, 32'(fp_bus.out_valid), 32'h1);
            check("fp_out_data",  k, fp_bus.out_data,       32'hE1);
            check("fp_out_sel",   k, 32'(fp_bus.out_sel),   32'h2);
        end
        check("fp_ch3_grants", 0, 32'(ch3_grants), 32'h0);

        // Fixed priority stall: consumer holds the entry, nothing is granted.
        drive_fp(4'b1110, 32'hE0, 1'b0);
        #1;
        check("fp_stall_ready", 0, 32'(fp_bus.in_ready), 32'h0);
        @(posedge clk);
        #1;
        check("fp_stall_valid", 0, 32'(fp_bus.out_valid), 32'h1);
        check("fp_stall_sel",   0, 32'(fp_bus.out_sel),   32'h2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rr_onehot_mux_reg.md
Name: rr_onehot_mux_reg

Overview:
- Registered N-input arbitrating multiplexer with valid/ready handshakes on every input and on the output.
- Each cycle a round-robin arbiter produces a one-hot grant among valid inputs; the granted payload is captured into a single-entry output register.
- Serves as the generic merge point for multiple producers onto one consumer, e.g. FU results onto a writeback port or miss requests onto a memory port.
- Replaces ad-hoc combinational select logic wherever more than one source can be valid at once.

Parameters:
- WIDTH, 32: payload width in bits.
- N_INS, 4: number of input channels; legal range 2..16.
- RR_EN, 1: 1 selects round-robin priority; 0 selects fixed priority, where the lowest index wins.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, N_INS: per-channel request.
- in_data, input, N_INS x WIDTH: per-channel payload; packed array, index [i][WIDTH-1:0].
- in_ready, output, N_INS: per-channel accept; one-hot or zero.
- out_valid, output, 1: output register holds a valid entry.
- out_data, output, WIDTH: registered payload.
- out_sel, output, N_INS: registered one-hot index of the source channel of out_data.
- out_ready, input, 1: consumer accepts the current output entry.

Behaviour:
- Reset: on a clk edge with rst=1, out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0 (channel 0 highest). in_ready is all zero while rst=1.
- can_load = !out_valid | out_ready. This allows the register to be refilled in the same cycle it drains, so throughput is 1 transfer/cycle.
- grant (combinational, one-hot or zero):
  - RR_EN=1: grant goes to the first valid channel scanning ptr, ptr+1, …, N_INS-1, 0, …, ptr-1, with modulo wrap.
  - RR_EN=0: grant goes to the lowest-index valid channel.
- in_ready = grant & {N_INS{can_load}}. in_ready never depends on in_data. Transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer from channel i: next cycle out_valid=1, out_data=in_data[i], out_sel=onehot(i). Latency is 1 cycle from input handshake to out_valid.
- If out_ready=1 and no input transfers: out_valid goes to 0 next cycle. out_data and out_sel hold their old values (don't-care when out_valid=0).
- If out_valid=1 and out_ready=0: out_valid, out_data and out_sel hold, and in_ready is all zero (backpressure to every channel).
- Pointer (RR_EN=1): after a transfer from channel i, ptr = (i+1) mod N_INS. ptr holds if there is no transfer. Wrap at i=N_INS-1 gives ptr=0.
- No valid inputs: grant=0, no state change except the drain described above.
- Fairness: with all channels continuously valid and out_ready=1, each channel is served exactly once every N_INS cycles.
- Reset mid-operation: a pending output entry is discarded (out_valid=0 next cycle) and ptr returns to 0. No transfer is counted in the reset cycle.
- Producer rule (checked by assertion in the bench, not enforced in RTL): once in_valid[i] is asserted, in_valid[i] and in_data[i] must stay stable until transferred.
- Embedded assertions, disabled during rst:
  - $onehot0(in_ready).
  - $onehot(out_sel) whenever out_valid.
  - out_valid & !out_ready implies stable out_data/out_sel next cycle.

Decomposition:
- Shared package (mux_pkg):
  - function onehot_to_idx (N_INS-wide one-hot to $clog2(N_INS) index).
  - function idx_to_onehot.
  - localparam PTR_W = $clog2(N_INS).
- Sub-module rr_arbiter #(N_INS, RR_EN): inputs req, ptr; output one-hot grant.
  - Purely combinational.
  - Implemented as a double-width masked priority scan; no break statements, so the loop is synthesizable and Icarus-compatible.
- Top level holds ptr, the output register and the handshake logic. The data select is an AND-OR reduction of in_data under grant.

Test Plan:
- Reset and idle: assert rst 2 cycles with all in_valid=1 -> in_ready=0 during reset. After release out_valid=0 and out_sel=0 in the first cycle; first transfer is from channel 0.
- Round-robin fairness (N_INS=4, RR_EN=1): in_valid=4'b1111, in_data[i]=32'hA0+i, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0 on consecutive cycles; out_sel = 0001,0010,0100,1000,0001.
- Pointer wrap and skip: grant channel 3, then in_valid=4'b0101 -> next grant is channel 0 (ptr wrapped to 0), then channel 2.
- Backpressure: out_valid=1 with out_data=0xDEAD, out_ready=0 for 5 cycles while in_valid=4'b0011 -> out_data stays 0xDEAD and in_ready=0 throughout. On the out_ready=1 cycle in_ready=0001 (or per ptr) and the new data appears the next cycle with no bubble.
- Fixed priority (RR_EN=0): in_valid=4'b1110 held, out_ready=1 -> channel 1 wins every cycle and channel 3 is never granted.
- Reset mid-stream: rst=1 while out_valid=1 and ptr=2 -> next cycle out_valid=0. After release with in_valid=4'b0101, channel 0 wins first.
